flight_mode_ctrl: RTL and testbench
===================================

Name: flight_mode_ctrl

Overview:
- Sequences flight-mode selection between the receiver channel decoder and the flight controller.
- Decodes the combined SWA/SWB receiver value into switch_a/switch_b codes and debounces them across receiver frames.
- Enforces an arm/disarm sequence gated on low throttle, with a hold timer.
- Forces a fixed safe mode on receiver loss (frame watchdog).

Parameters:
- DEBOUNCE_FRAMES, 3: consecutive identical valid frames required before a decoded mode is committed (range 1..15).
- ARM_HOLD_US, 1000000: us_clk cycles throttle must stay low in ARMING before entering ARMED.
- TIMEOUT_US, 100000: us_clk cycles without a valid frame before entering FAILSAFE.
- THR_LOW_MAX, 8'd10: throttle_val at or below this value counts as "low".

Ports:
- us_clk  input  1  1 MHz system clock.
- resetn  input  1  asynchronous, active-low reset.
- rec_valid  input  1  one-cycle strobe: new receiver frame; swa_swb_val and throttle_val are valid this cycle.
- swa_swb_val  input  REC_VAL_BIT_WIDTH (8)  combined switch channel value.
- throttle_val  input  REC_VAL_BIT_WIDTH (8)  throttle channel value.
- switch_a  output  3  committed SWA mode, one-hot.
- switch_b  output  2  committed SWB position.
- armed  output  1  high only in ARMED.
- failsafe  output  1  high only in FAILSAFE.
- mode_change  output  1  one-cycle pulse when switch_a or switch_b changes value.

Behaviour:
- Reset values (async):
  - switch_a=000, switch_b=00, armed=0, failsafe=0, mode_change=0.
  - State DISARMED; debounce count, hold timer and watchdog all 0.
  - Candidate register = 000/00.
  - Reset mid-operation aborts everything to these values.
- Band decode (combinational, inclusive bounds):
  - 0-49 -> 100/01
  - 50-99 -> 100/10
  - 100-149 -> 001/11 (mode 0)
  - 150-199 -> 010/10
  - 200-250 -> 010/01
  - 251-255 -> invalid
- A "valid frame" is rec_valid=1 with a non-invalid decode.
- Invalid frames reset the debounce count to 0. They do not reload the watchdog and do not advance arming.
- Debounce:
  - On a valid frame, if the decode equals the candidate, the count increments (saturating at DEBOUNCE_FRAMES).
  - Otherwise the candidate is replaced and the count is set to 1.
  - When the count reaches DEBOUNCE_FRAMES, the candidate is committed to switch_a/switch_b on that same us_clk edge (zero added latency).
  - mode_change is asserted on the next cycle for exactly 1 cycle, only if the committed value differs from the previous one.
- Watchdog:
  - Reloaded to TIMEOUT_US on every valid frame; otherwise decrements each cycle.
  - Expiry (reaches 0) in any state except FAILSAFE -> FAILSAFE.
  - If a valid frame arrives on the same cycle as expiry, the frame wins: the watchdog reloads and there is no failsafe.
- State machine:
  - DISARMED -> ARMING: valid frame with committed mode 001/11 and throttle_val <= THR_LOW_MAX. The hold timer loads ARM_HOLD_US.
  - ARMING:
    - Hold timer decrements each cycle.
    - A valid frame with throttle > THR_LOW_MAX, or with committed mode != 001/11, returns to DISARMED.
    - Timer reaching 0 -> ARMED; armed=1 on the following cycle.
  - ARMED -> DISARMED: valid frame with committed mode 100/01 and throttle low. Mode commits continue normally while ARMED.
  - FAILSAFE:
    - switch_a/switch_b forced to 001/11 (mode_change pulses if this differs); armed=0; failsafe=1.
    - Debounce count cleared on entry.
    - Exit to DISARMED once DEBOUNCE_FRAMES consecutive valid frames are received. The committed mode then comes from the candidate.
    - A FAILSAFE exit never goes directly to ARMED.
- Arming and disarm checks use the committed mode as updated on the same edge.
- Widths: timers are $clog2(max(ARM_HOLD_US, TIMEOUT_US)+1) bits and unsigned; the debounce counter is 4 bits.

Decomposition:
- Shared package (common_defines.v):
  - REC_VAL_BIT_WIDTH.
  - Band bounds (49/99/149/199/250).
  - Switch_a/switch_b encodings.
  - State encodings FM_DISARMED/FM_ARMING/FM_ARMED/FM_FAILSAFE.
- One sub-module: fm_band_decoder, a combinational value -> {valid, switch_a, switch_b} decoder. It is reused by other channel logic.

Test Plan:
- Reset, then 3 frames of swa_swb_val=175 spaced 20000 cycles -> switch_a=010, switch_b=10 after the third frame; single mode_change pulse; armed=0.
- Frames 120,120,60,60,60 (DEBOUNCE_FRAMES=3) -> no commit after the 120s; commit 100/10 on the fifth frame; a lone 255 frame inserted mid-sequence restarts the count.
- ARM_HOLD_US=50: commit 001/11, throttle=5 frames -> ARMING, then armed=1 about 51 cycles later; repeat with a throttle=200 frame during hold -> DISARMED, armed=0.
- TIMEOUT_US=1000, armed: stop frames -> failsafe=1 at cycle 1000, switch 001/11, armed=0; 3 frames of 30 -> DISARMED, 100/01, failsafe=0.
- rec_valid on the exact watchdog-expiry cycle -> failsafe stays 0, watchdog reloads.
- resetn low while ARMED -> all outputs return to reset values asynchronously; after release, re-arming requires the full sequence.

Source files
------------

// File: rtl/flight_mode_ctrl_pkg.sv
// Shared definitions for flight-mode sequencing: receiver value width, switch band
// bounds, switch_a/switch_b encodings, the committed-mode struct and FSM states.
// No ports; imported by fm_band_decoder and flight_mode_ctrl.
package flight_mode_ctrl_pkg;

  localparam int REC_VAL_BIT_WIDTH = 8;

  // Inclusive upper bounds of the five SWA/SWB bands; anything above BAND4_MAX is invalid.
  localparam logic [REC_VAL_BIT_WIDTH-1:0] BAND0_MAX = 8'd49;
  localparam logic [REC_VAL_BIT_WIDTH-1:0] BAND1_MAX = 8'd99;
  localparam logic [REC_VAL_BIT_WIDTH-1:0] BAND2_MAX = 8'd149;
  localparam logic [REC_VAL_BIT_WIDTH-1:0] BAND3_MAX = 8'd199;
  localparam logic [REC_VAL_BIT_WIDTH-1:0] BAND4_MAX = 8'd250;

  // switch_a is one-hot, switch_b is a 2-bit position code.
  localparam logic [2:0] SWA_MODE0 = 3'b001;
  localparam logic [2:0] SWA_MODE1 = 3'b010;
  localparam logic [2:0] SWA_MODE2 = 3'b100;
  localparam logic [1:0] SWB_POS1  = 2'b01;
  localparam logic [1:0] SWB_POS2  = 2'b10;
  localparam logic [1:0] SWB_POS3  = 2'b11;

  typedef struct packed {
    logic [2:0] swa;
    logic [1:0] swb;
  } fm_mode_t;

  localparam fm_mode_t FM_MODE_NONE   = '0;
  // Mode 0 doubles as the arming mode and the failsafe-forced mode.
  localparam fm_mode_t FM_MODE_ARM    = '{swa: SWA_MODE0, swb: SWB_POS3};
  localparam fm_mode_t FM_MODE_DISARM = '{swa: SWA_MODE2, swb: SWB_POS1};

  typedef enum logic [1:0] {
    FM_DISARMED = 2'd0,
    FM_ARMING   = 2'd1,
    FM_ARMED    = 2'd2,
    FM_FAILSAFE = 2'd3
  } fm_state_t;

endpackage

// File: rtl/fm_band_decoder.sv
// Combinational receiver-value band decoder: val -> {valid, switch_a, switch_b}.
// Ports: val (receiver channel value), valid (0 for values above the top band),
// switch_a (one-hot SWA code), switch_b (SWB position code); outputs are 0 when invalid.
module fm_band_decoder
  import flight_mode_ctrl_pkg::*;
(
  input  logic [REC_VAL_BIT_WIDTH-1:0] val,
  output logic                         valid,
  output logic [2:0]                   switch_a,
  output logic [1:0]                   switch_b
);

  always_comb begin
    valid    = 1'b1;
    switch_a = '0;
    switch_b = '0;
    if (val <= BAND0_MAX) begin
      switch_a = SWA_MODE2;
      switch_b = SWB_POS1;
    end else if (val <= BAND1_MAX) begin
      switch_a = SWA_MODE2;
      switch_b = SWB_POS2;
    end else if (val <= BAND2_MAX) begin
      switch_a = SWA_MODE0;
      switch_b = SWB_POS3;
    end else if (val <= BAND3_MAX) begin
      switch_a = SWA_MODE1;
      switch_b = SWB_POS2;
    end else if (val <= BAND4_MAX) begin
      switch_a = SWA_MODE1;
      switch_b = SWB_POS1;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/flight_mode_ctrl.sv
// Flight-mode sequencer: debounces decoded SWA/SWB frames into a committed mode,
// runs the DISARMED/ARMING/ARMED/FAILSAFE sequence and a receiver-loss watchdog.
// Ports: us_clk/resetn; rec_valid strobe with swa_swb_val and throttle_val; registered
// outputs switch_a, switch_b, armed, failsafe and a one-cycle mode_change pulse.
module flight_mode_ctrl
  import flight_mode_ctrl_pkg::*;
#(
  parameter int unsigned                    DEBOUNCE_FRAMES = 3,
  parameter int unsigned                    ARM_HOLD_US     = 1000000,
  parameter int unsigned                    TIMEOUT_US      = 100000,
  parameter logic [REC_VAL_BIT_WIDTH-1:0]   THR_LOW_MAX     = 8'd10
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         rec_valid,
  input  logic [REC_VAL_BIT_WIDTH-1:0] swa_swb_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
  output logic [2:0]                   switch_a,
  output logic [1:0]                   switch_b,
  output logic                         armed,
  output logic                         failsafe,
  output logic                         mode_change
);

  localparam int unsigned TMR_MAX = (ARM_HOLD_US > TIMEOUT_US) ? ARM_HOLD_US : TIMEOUT_US;
  localparam int          TW      = $clog2(TMR_MAX + 1);

  localparam logic [TW-1:0] HOLD_LOAD = TW'(ARM_HOLD_US);
  localparam logic [TW-1:0] WD_LOAD   = TW'(TIMEOUT_US);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [3:0]    DEB_CNT   = 4'(DEBOUNCE_FRAMES);

  fm_state_t     state_q;
  fm_mode_t      cand_q;
  fm_mode_t      cand_n;
  fm_mode_t      dec_mode;
  fm_mode_t      cm_q;
  fm_mode_t      cm_n;
  fm_mode_t      sw_out_n;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_n;
  logic [TW-1:0] wd_q;
  logic [TW-1:0] hold_q;
  logic          dec_vld;
  logic [2:0]    dec_a;
  logic [1:0]    dec_b;
  logic          frame_ok;
  logic          thr_low;
  logic          commit;
  logic          wd_expire;
  logic          enter_fs;

  fm_band_decoder u_band_decoder (
    .val      (swa_swb_val),
    .valid    (dec_vld),
    .switch_a (dec_a),
    .switch_b (dec_b)
  );

  assign dec_mode = {dec_a, dec_b};
  assign cm_q     = {switch_a, switch_b};
  assign frame_ok = rec_valid & dec_vld;
  assign thr_low  = (throttle_val <= THR_LOW_MAX);

  // Expiry is the 1 -> 0 step of the watchdog; a valid frame on that cycle reloads
  // it instead. A watchdog sitting at 0 (before the first frame, or already in
  // FAILSAFE) does not re-trigger.
  assign wd_expire = !frame_ok && (wd_q == TMR_ONE);
  assign enter_fs  = wd_expire && (state_q != FM_FAILSAFE);

  // Debounce and commit. The commit lands on the same edge as the qualifying frame,
  // so the FSM below sees the freshly committed mode through cm_n.
  always_comb begin
    cand_n = cand_q;
    cnt_n  = cnt_q;
    if (frame_ok) begin
      if (dec_mode == cand_q) begin
        cnt_n = (cnt_q >= DEB_CNT) ? DEB_CNT : cnt_q + 4'd1;
      end else begin
        cand_n = dec_mode;
        cnt_n  = 4'd1;
      end
    end else if (rec_valid) begin
      cnt_n = 4'd0;
    end
    commit   = frame_ok && (cnt_n == DEB_CNT);
    cm_n     = commit ? cand_n : cm_q;
    // Entering FAILSAFE cannot coincide with a commit (it needs a missing frame).
    sw_out_n = enter_fs ? FM_MODE_ARM : cm_n;
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= FM_DISARMED;
      cand_q      <= FM_MODE_NONE;
      cnt_q       <= '0;
      wd_q        <= '0;
      hold_q      <= '0;
      switch_a    <= '0;
      switch_b    <= '0;
      armed       <= 1'b0;
      failsafe    <= 1'b0;
      mode_change <= 1'b0;
    end else begin
      cand_q      <= cand_n;
      cnt_q       <= enter_fs ? 4'd0 : cnt_n;
      switch_a    <= sw_out_n.swa;
      switch_b    <= sw_out_n.swb;
      mode_change <= (sw_out_n != cm_q);

      if (frame_ok) begin
        wd_q <= WD_LOAD;
      end else if (wd_q != '0) begin
        wd_q <= wd_q - TMR_ONE;
      end

      case (state_q)
        FM_DISARMED: begin
          if (enter_fs) begin
            state_q  <= FM_FAILSAFE;
            failsafe <= 1'b1;
          end else if (frame_ok && (cm_n == FM_MODE_ARM) && thr_low) begin
            state_q <= FM_ARMING;
            hold_q  <= HOLD_LOAD;
          end
        end
        FM_ARMING: begin
          if (enter_fs) begin
            state_q  <= FM_FAILSAFE;
            failsafe <= 1'b1;
          end else if (frame_ok && (!thr_low || (cm_n != FM_MODE_ARM))) begin
            state_q <= FM_DISARMED;
          end else if (hold_q == '0) begin
            state_q <= FM_ARMED;
            armed   <= 1'b1;
          end else begin
            hold_q <= hold_q - TMR_ONE;
          end
        end
        FM_ARMED: begin
          if (enter_fs) begin
            state_q  <= FM_FAILSAFE;
            armed    <= 1'b0;
            failsafe <= 1'b1;
          end else if (frame_ok && (cm_n == FM_MODE_DISARM) && thr_low) begin
            state_q <= FM_DISARMED;
            armed   <= 1'b0;
          end
        end
        FM_FAILSAFE: begin
          // Leaving needs a full debounce run from the cleared count; always via DISARMED.
          if (commit) begin
            state_q  <= FM_DISARMED;
            failsafe <= 1'b0;
          end
        end
        default: begin
          state_q  <= FM_DISARMED;
          armed    <= 1'b0;
          failsafe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flight_mode_ctrl.sv
module tb_flight_mode_ctrl;

  logic       us_clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rec_valid = 1'b0;
  logic [7:0] swa_swb_val = 8'd0;
  logic [7:0] throttle_val = 8'd100;
  logic [2:0] switch_a;
  logic [1:0] switch_b;
  logic       armed;
  logic       failsafe;
  logic       mode_change;

  int errors = 0;
  int checks = 0;

  flight_mode_ctrl #(
    .DEBOUNCE_FRAMES (3),
    .ARM_HOLD_US     (50),
    .TIMEOUT_US      (1000),
    .THR_LOW_MAX     (8'd10)
  ) dut (
    .us_clk       (us_clk),
    .resetn       (resetn),
    .rec_valid    (rec_valid),
    .swa_swb_val  (swa_swb_val),
    .throttle_val (throttle_val),
    .switch_a     (switch_a),
    .switch_b     (switch_b),
    .armed        (armed),
    .failsafe     (failsafe),
    .mode_change  (mode_change)
  );

  always #5 us_clk = ~us_clk;

  // One receiver frame on a single edge; returns 1 ns after that edge.
  task automatic send_frame(input logic [7:0] sv, input logic [7:0] thr);
    @(negedge us_clk);
    rec_valid    = 1'b1;
    swa_swb_val  = sv;
    throttle_val = thr;
    @(posedge us_clk);
    #1;
    rec_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge us_clk);
    #1;
  endtask

  task automatic test_reset;
    idle(2);
    checks++;
    if ({switch_a, switch_b, armed, failsafe, mode_change} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {switch_a, switch_b, armed, failsafe, mode_change}, 8'b0);
    end
    @(negedge us_clk);
    resetn = 1'b1;
    idle(2);
    checks++;
    if ({switch_a, switch_b, armed, failsafe, mode_change} !== 8'b0) begin
      errors++;
      $display("FAIL post_release got=%b exp=%b", {switch_a, switch_b, armed, failsafe, mode_change}, 8'b0);
    end
  endtask

  task automatic test_first_commit;
    send_frame(8'd175, 8'd100);
    idle(200);
    send_frame(8'd175, 8'd100);
    checks++;
    if ({switch_a, switch_b, mode_change} !== 6'b000_00_0) begin
      errors++;
      $display("FAIL first_no_commit got=%b exp=%b", {switch_a, switch_b, mode_change}, 6'b000_00_0);
    end
    idle(200);
    send_frame(8'd175, 8'd100);
    checks++;
    if ({switch_a, switch_b, mode_change, armed} !== 7'b010_10_1_0) begin
      errors++;
      $display("FAIL first_commit got=%b exp=%b", {switch_a, switch_b, mode_change, armed}, 7'b010_10_1_0);
    end
    idle(1);
    checks++;
    if (mode_change !== 1'b0) begin
      errors++;
      $display("FAIL first_pulse_width got=%b exp=0", mode_change);
    end
    idle(20);
  endtask

  task automatic test_debounce;
    send_frame(8'd120, 8'd100);
    send_frame(8'd120, 8'd100);
    send_frame(8'd60, 8'd100);
    send_frame(8'd60, 8'd100);
    checks++;
    if ({switch_a, switch_b} !== 5'b010_10) begin
      errors++;
      $display("FAIL deb_hold got=%b exp=%b", {switch_a, switch_b}, 5'b010_10);
    end
    send_frame(8'd60, 8'd100);
    checks++;
    if ({switch_a, switch_b, mode_change} !== 6'b100_10_1) begin
      errors++;
      $display("FAIL deb_commit got=%b exp=%b", {switch_a, switch_b, mode_change}, 6'b100_10_1);
    end
    // An invalid frame mid-run restarts the count.
    send_frame(8'd175, 8'd100);
    send_frame(8'd175, 8'd100);
    send_frame(8'd255, 8'd100);
    send_frame(8'd175, 8'd100);
    send_frame(8'd175, 8'd100);
    checks++;
    if ({switch_a, switch_b} !== 5'b100_10) begin
      errors++;
      $display("FAIL deb_invalid_restart got=%b exp=%b", {switch_a, switch_b}, 5'b100_10);
    end
    send_frame(8'd175, 8'd100);
    checks++;
    if ({switch_a, switch_b} !== 5'b010_10) begin
      errors++;
      $display("FAIL deb_recommit got=%b exp=%b", {switch_a, switch_b}, 5'b010_10);
    end
    idle(5);
  endtask

  task automatic test_arm;
    for (int i = 0; i < 3; i++) send_frame(8'd120, 8'd5);
    checks++;
    if ({switch_a, switch_b, armed} !== 6'b001_11_0) begin
      errors++;
      $display("FAIL arm_commit got=%b exp=%b", {switch_a, switch_b, armed}, 6'b001_11_0);
    end
    idle(50);
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_hold_early got=%b exp=0", armed);
    end
    idle(1);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL arm_hold_done got=%b exp=1", armed);
    end
    for (int i = 0; i < 3; i++) send_frame(8'd30, 8'd5);
    checks++;
    if ({switch_a, switch_b, armed} !== 6'b100_01_0) begin
      errors++;
      $display("FAIL disarm got=%b exp=%b", {switch_a, switch_b, armed}, 6'b100_01_0);
    end
    // High throttle during the hold aborts arming.
    for (int i = 0; i < 3; i++) send_frame(8'd120, 8'd5);
    idle(10);
    send_frame(8'd120, 8'd200);
    idle(60);
    checks++;
    if (armed !== 1'b0) begin
      errors++;
      $display("FAIL arm_abort got=%b exp=0", armed);
    end
  endtask

  task automatic test_failsafe;
    send_frame(8'd120, 8'd5);
    idle(51);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL fs_pre_armed got=%b exp=1", armed);
    end
    idle(948);
    checks++;
    if (failsafe !== 1'b0) begin
      errors++;
      $display("FAIL fs_early got=%b exp=0", failsafe);
    end
    idle(1);
    checks++;
    if ({switch_a, switch_b, armed, failsafe} !== 7'b001_11_0_1) begin
      errors++;
      $display("FAIL fs_entry got=%b exp=%b", {switch_a, switch_b, armed, failsafe}, 7'b001_11_0_1);
    end
    send_frame(8'd30, 8'd5);
    send_frame(8'd30, 8'd5);
    checks++;
    if ({switch_a, switch_b, failsafe} !== 6'b001_11_1) begin
      errors++;
      $display("FAIL fs_stay got=%b exp=%b", {switch_a, switch_b, failsafe}, 6'b001_11_1);
    end
    send_frame(8'd30, 8'd5);
    checks++;
    if ({switch_a, switch_b, armed, failsafe, mode_change} !== 8'b100_01_0_0_1) begin
      errors++;
      $display("FAIL fs_exit got=%b exp=%b", {switch_a, switch_b, armed, failsafe, mode_change}, 8'b100_01_0_0_1);
    end
  endtask

  task automatic test_expiry_race;
    idle(999);
    send_frame(8'd30, 8'd5);
    checks++;
    if (failsafe !== 1'b0) begin
      errors++;
      $display("FAIL race_no_fs got=%b exp=0", failsafe);
    end
    idle(999);
    checks++;
    if (failsafe !== 1'b0) begin
      errors++;
      $display("FAIL race_reload got=%b exp=0", failsafe);
    end
    idle(1);
    checks++;
    if (failsafe !== 1'b1) begin
      errors++;
      $display("FAIL race_expire got=%b exp=1", failsafe);
    end
  endtask

  task automatic test_reset_armed;
    for (int i = 0; i < 3; i++) send_frame(8'd120, 8'd5);
    checks++;
    if ({switch_a, switch_b, armed, failsafe} !== 7'b001_11_0_0) begin
      errors++;
      $display("FAIL rst_fs_exit got=%b exp=%b", {switch_a, switch_b, armed, failsafe}, 7'b001_11_0_0);
    end
    send_frame(8'd120, 8'd5);
    idle(51);
    checks++;
    if (armed !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_armed got=%b exp=1", armed);
    end
    @(negedge us_clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({switch_a, switch_b, armed, failsafe, mode_change} !== 8'b0) begin
      errors++;
      $display("FAIL rst_async got=%b exp=%b", {switch_a, switch_b, armed, failsafe, mode_change}, 8'b0);
    end
    #9 resetn = 1'b1;
    send_frame(8'd120, 8'd5);
    idle(60);
    checks++;
    if ({switch_a, switch_b, armed} !== 6'b000_00_0) begin
      errors++;
      $display("FAIL rst_no_rearm got=%b exp=%b", {switch_a, switch_b, armed}, 6'b000_00_0);
    end
    send_frame(8'd120, 8'd5);
    send_frame(8'd120, 8'd5);
    idle(51);
    checks++;
    if ({switch_a, switch_b, armed} !== 6'b001_11_1) begin
      errors++;
      $display("FAIL rst_rearm got=%b exp=%b", {switch_a, switch_b, armed}, 6'b001_11_1);
    end
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_debounce();
    test_arm();
    test_failsafe();
    test_expiry_race();
    test_reset_armed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
